pingpong_pkt_framer: RTL and testbench
======================================

// Module: pingpong_pkt_framer
// PURPOSE
//   Parametrised ping-pong packet buffer between the UART receive and transmit
//   paths. Incoming bytes fill one bank while the other bank drains to the TX
//   path over a valid/ready stream. A parallel sensor field (e.g. SPI readings)
//   overwrites a fixed byte window inside every packet. The block raises a
//   sensor request at a programmable byte position and detects drain overruns.
// PARAMETERS
//   PKT_LEN        48    bytes per packet; byte index wraps PKT_LEN-1 -> 0
//   PKTS_PER_BANK  8     in_eop count that triggers a bank swap
//   INS_OFS        35    first packet byte replaced by field data
//   INS_BYTES      11    bytes replaced; INS_OFS+INS_BYTES <= PKT_LEN
//   REQ_OFS        2     packet byte index whose acceptance pulses field_req
//   ADDR_W         9     bank address width; 2**ADDR_W >= PKT_LEN*PKTS_PER_BANK
// PORTS
//   clk         in   1             single clock, all logic on rising edge
//   rst_n       in   1             asynchronous active-low reset
//   in_valid    in   1             in_data valid for one cycle (rx_ready strobe)
//   in_data     in   8             received byte
//   in_eop      in   1             end-of-packet pulse (rx idle detected)
//   field_req   out  1             1-cycle pulse: start sensor read
//   field_valid in   1             field_data valid; latched on this cycle
//   field_data  in   INS_BYTES*8   sensor field, MSB byte is inserted first
//   out_valid   out  1             out_data valid; held until out_ready
//   out_data    out  8             drained byte
//   out_last    out  1             qualifies the final byte of a bank drain
//   out_ready   in   1             TX path accepts byte when valid&ready
//   bank_sel    out  1             bank currently being filled (0/1)
//   drain_busy  out  1             drain of the other bank in progress
//   overrun     out  1             1-cycle pulse: filled bank discarded
// BEHAVIOUR
//   Reset: all outputs 0; wr_ptr, pkt_idx, eop_cnt and rd_ptr are 0; field_lat is 0.
//   Fill: on in_valid, write to bank[bank_sel][wr_ptr], then increment wr_ptr and pkt_idx.
//     - Write byte k of the field window (pkt_idx = INS_OFS+k, k < INS_BYTES) from
//       field_lat[8*(INS_BYTES-k)-1 -: 8]. Write all other positions from in_data.
//     - wr_ptr saturates at PKT_LEN*PKTS_PER_BANK. Further bytes are dropped, with no
//       pointer wrap.
//     - field_req pulses the cycle after an accepted byte whose pkt_idx == REQ_OFS.
//     - field_lat <= field_data on field_valid. The latch keeps its last value otherwise.
//   in_eop: pkt_idx <= 0 and eop_cnt++.
//     - If in_valid and in_eop arrive in the same cycle, the byte is written at the old
//       pkt_idx first, then pkt_idx resets.
//   Swap: evaluated the cycle eop_cnt reaches PKTS_PER_BANK.
//     - If drain_busy = 0: toggle bank_sel, set rd_len <= wr_ptr, rd_ptr <= 0, and set
//       drain_busy if rd_len != 0. Then clear wr_ptr and eop_cnt.
//     - If drain_busy = 1: bank_sel is unchanged. The fill bank is discarded (wr_ptr and
//       eop_cnt cleared) and overrun pulses.
//   Drain: a state machine with states IDLE -> RD (issue bank read) -> HOLD (wait out_ready).
//     - RAM read latency is 1 cycle. out_valid rises 2 cycles after swap.
//     - out_data and out_last stay stable while out_valid & ~out_ready.
//     - When valid&ready: if rd_ptr == rd_len-1, go to IDLE and clear drain_busy and
//       out_valid. Otherwise increment rd_ptr and return to RD.
//     - A 0-byte swap produces no output and drain_busy stays 0.
//   Bank storage is inferred single-port per bank. A bank is never read and written in
//     the same cycle.
//   Reset asserted mid-operation aborts fill and drain immediately. No byte is output after
//     rst_n deasserts until a new swap.
// TESTING
//   1. Feed 8 packets x 48 bytes 0x00..0x2F with field_valid=0 before them. After the 8th
//      in_eop, expect 384 bytes out. Bytes 35..45 of each packet are 0x00; others match
//      the input. out_last is set on byte 384 only, and bank_sel toggles.
//   2. Pulse field_valid with 0x0102..0B each packet. Expect bytes 35..45 = 01..0B in
//      order, and field_req pulsed once per packet after byte 2.
//   3. Start a second 8-packet fill while out_ready=0 holds the drain. Expect an overrun
//      pulse at the 8th in_eop, bank_sel unchanged, and the drain later completes with
//      the original data.
//   4. Hold out_ready low for 10 cycles mid-drain. Expect out_data stable, no bytes lost
//      or duplicated, and 1 byte/2 cycles throughput when out_ready=1.
//   5. Send in_valid and in_eop in the same cycle, then send 400 bytes in one bank. Expect
//      the byte kept, pkt_idx restarted at 0, and bytes past 384 dropped.
//   6. Assert rst_n low during a drain. Expect out_valid=0 within the same cycle, and no
//      output until a new full bank swap.

Source files
------------

// File: rtl/pingpong_pkt_framer.sv
// Ping-pong packet buffer: one bank fills from the RX byte stream while the other
// drains over valid/ready. A latched sensor field is spliced into every packet.
module pingpong_pkt_framer #(
    parameter int unsigned PKT_LEN       = 48,
    parameter int unsigned PKTS_PER_BANK = 8,
    parameter int unsigned INS_OFS       = 35,
    parameter int unsigned INS_BYTES     = 11,
    parameter int unsigned REQ_OFS       = 2,
    parameter int unsigned ADDR_W        = 9
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    input  logic                   in_eop,
    output logic                   field_req,
    input  logic                   field_valid,
    input  logic [INS_BYTES*8-1:0] field_data,
    output logic                   out_valid,
    output logic [7:0]             out_data,
    output logic                   out_last,
    input  logic                   out_ready,
    output logic                   bank_sel,
    output logic                   drain_busy,
    output logic                   overrun
);

    localparam int unsigned BANK_BYTES = PKT_LEN * PKTS_PER_BANK;
    localparam int unsigned DEPTH      = 2 ** ADDR_W;
    localparam int unsigned PTR_W      = ADDR_W + 1;
    localparam int unsigned IDX_W      = $clog2(PKT_LEN);
    localparam int unsigned CNT_W      = $clog2(PKTS_PER_BANK + 1);
    localparam int unsigned FLD_W      = INS_BYTES * 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               bank_sel_q, bank_sel_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [IDX_W-1:0]   pkt_idx_q, pkt_idx_d;
    logic [CNT_W-1:0]   eop_cnt_q, eop_cnt_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   rd_len_q, rd_len_d;
    logic               drain_busy_q, drain_busy_d;
    logic [FLD_W-1:0]   field_lat_q, field_lat_d;
    logic               out_valid_q, out_valid_d;
    logic [7:0]         out_data_q, out_data_d;
    logic               out_last_q, out_last_d;
    logic               field_req_q, field_req_d;
    logic               overrun_q, overrun_d;

    logic [7:0]         mem0 [DEPTH];
    logic [7:0]         mem1 [DEPTH];

    logic               accept;
    logic               in_window;
    logic [IDX_W-1:0]   ins_k_rev;
    logic               wr_en;
    logic [7:0]         wr_byte;
    logic [7:0]         rd_word;
    logic               rd_last;

    always_comb begin
        state_d      = state_q;
        bank_sel_d   = bank_sel_q;
        wr_ptr_d     = wr_ptr_q;
        pkt_idx_d    = pkt_idx_q;
        eop_cnt_d    = eop_cnt_q;
        rd_ptr_d     = rd_ptr_q;
        rd_len_d     = rd_len_q;
        drain_busy_d = drain_busy_q;
        field_lat_d  = field_lat_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        field_req_d  = 1'b0;
        overrun_d    = 1'b0;
        wr_en        = 1'b0;
        wr_byte      = in_data;

        // Field window: byte k of the window takes field byte k counted from the MSB end.
        in_window = ({1'b0, pkt_idx_q} >= (IDX_W+1)'(INS_OFS)) &&
                    ({1'b0, pkt_idx_q} <  (IDX_W+1)'(INS_OFS + INS_BYTES));
        ins_k_rev = IDX_W'(INS_OFS + INS_BYTES - 1) - pkt_idx_q;
        if (in_window) begin
            wr_byte = 8'(field_lat_q >> {ins_k_rev, 3'b000});
        end

        rd_word = bank_sel_q ? mem0[rd_ptr_q[ADDR_W-1:0]] : mem1[rd_ptr_q[ADDR_W-1:0]];
        rd_last = (rd_ptr_q == rd_len_q - PTR_W'(1));
        accept  = in_valid && (wr_ptr_q != PTR_W'(BANK_BYTES));

        if (accept) begin
            wr_en       = 1'b1;
            wr_ptr_d    = wr_ptr_q + PTR_W'(1);
            pkt_idx_d   = (pkt_idx_q == IDX_W'(PKT_LEN - 1)) ? '0 : pkt_idx_q + IDX_W'(1);
            field_req_d = (pkt_idx_q == IDX_W'(REQ_OFS));
        end

        if (field_valid) begin
            field_lat_d = field_data;
        end

        // End of packet; the last one of a bank either hands the bank to the drain or discards it.
        if (in_eop) begin
            pkt_idx_d = '0;
            if (eop_cnt_q == CNT_W'(PKTS_PER_BANK - 1)) begin
                if (!drain_busy_q) begin
                    bank_sel_d   = ~bank_sel_q;
                    rd_len_d     = wr_ptr_d;
                    rd_ptr_d     = '0;
                    drain_busy_d = (wr_ptr_d != '0);
                end else begin
                    overrun_d = 1'b1;
                end
                wr_ptr_d  = '0;
                eop_cnt_d = '0;
            end else begin
                eop_cnt_d = eop_cnt_q + CNT_W'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (drain_busy_q) begin
                    state_d = ST_RD;
                end
            end
            ST_RD: begin
                out_data_d  = rd_word;
                out_last_d  = rd_last;
                out_valid_d = 1'b1;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (rd_last) begin
                        drain_busy_d = 1'b0;
                        state_d      = ST_IDLE;
                    end else begin
                        rd_ptr_d = rd_ptr_q + PTR_W'(1);
                        state_d  = ST_RD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            bank_sel_q   <= 1'b0;
            wr_ptr_q     <= '0;
            pkt_idx_q    <= '0;
            eop_cnt_q    <= '0;
            rd_ptr_q     <= '0;
            rd_len_q     <= '0;
            drain_busy_q <= 1'b0;
            field_lat_q  <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            field_req_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bank_sel_q   <= bank_sel_d;
            wr_ptr_q     <= wr_ptr_d;
            pkt_idx_q    <= pkt_idx_d;
            eop_cnt_q    <= eop_cnt_d;
            rd_ptr_q     <= rd_ptr_d;
            rd_len_q     <= rd_len_d;
            drain_busy_q <= drain_busy_d;
            field_lat_q  <= field_lat_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            field_req_q  <= field_req_d;
            overrun_q    <= overrun_d;
        end
    end

    // Bank storage; the drain always reads the bank opposite the one being written.
    always_ff @(posedge clk) begin
        if (wr_en && !bank_sel_q) begin
            mem0[wr_ptr_q[ADDR_W-1:0]] <= wr_byte;
        end
        if (wr_en && bank_sel_q) begin
            mem1[wr_ptr_q[ADDR_W-1:0]] <= wr_byte;
        end
    end

    assign field_req  = field_req_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    assign bank_sel   = bank_sel_q;
    assign drain_busy = drain_busy_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_pingpong_pkt_framer.sv
// Directed bench for pingpong_pkt_framer: fills, drains, field splice, overrun,
// back-pressure, saturation and mid-drain reset.
module tb_pingpong_pkt_framer;

    localparam int unsigned BANK_BYTES = 384;
    localparam logic [87:0] FLD        = 88'h0102030405060708090A0B;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_eop = 1'b0;
    logic        field_valid = 1'b0;
    logic [87:0] field_data = '0;
    logic        out_ready = 1'b0;
    logic        field_req, out_valid, out_last, bank_sel, drain_busy, overrun;
    logic [7:0]  out_data;

    int total = 0;
    int bad = 0;

    logic [7:0]  cap[$];
    int          cap_t[$];
    logic [7:0]  exp_fill[$];
    logic [7:0]  exp_drain[$];
    int          last_cnt = 0, last_idx = 0, req_cnt = 0, ovr_cnt = 0;
    int          hold_cnt = 0, hold_err = 0;
    logic        prev_hold = 1'b0, prev_last = 1'b0;
    logic [7:0]  prev_data = 8'h00;

    int          wcnt = 0, tb_idx = 0;
    logic [87:0] tb_lat = '0;

    pingpong_pkt_framer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_eop(in_eop),
        .field_req(field_req), .field_valid(field_valid), .field_data(field_data),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .bank_sel(bank_sel), .drain_busy(drain_busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_hold) begin
                hold_cnt <= hold_cnt + 1;
                if (!(out_valid === 1'b1 && out_data === prev_data && out_last === prev_last))
                    hold_err <= hold_err + 1;
            end
            if (out_valid && out_ready) begin
                cap.push_back(out_data);
                cap_t.push_back(int'($time / 10));
                if (out_last) begin
                    last_cnt <= last_cnt + 1;
                    last_idx <= cap.size() - 1;
                end
            end
            if (field_req) req_cnt <= req_cnt + 1;
            if (overrun)   ovr_cnt <= ovr_cnt + 1;
        end
        prev_hold <= rst_n && out_valid && !out_ready;
        prev_data <= out_data;
        prev_last <= out_last;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One input cycle; the bench's own model of the stored byte and of field_req.
    task automatic drive(input logic v, input logic [7:0] d, input logic e, input logic fv);
        logic [7:0] expb;
        logic       acc, req_exp;
        in_valid    = v;
        in_data     = d;
        in_eop      = e;
        field_valid = fv;
        field_data  = fv ? FLD : {11{8'hA5}};
        acc     = v && (wcnt < BANK_BYTES);
        req_exp = acc && (tb_idx == 2);
        if (acc) begin
            if (tb_idx >= 35 && tb_idx < 46) expb = 8'(tb_lat >> (8 * (45 - tb_idx)));
            else                             expb = d;
            exp_fill.push_back(expb);
            wcnt++;
            tb_idx = (tb_idx == 47) ? 0 : tb_idx + 1;
        end
        if (e)  tb_idx = 0;
        if (fv) tb_lat = FLD;
        @(posedge clk); #1;
        check("field_req", 32'(field_req), 32'(req_exp));
        in_valid    = 1'b0;
        in_eop      = 1'b0;
        field_valid = 1'b0;
    endtask

    task automatic send_pkt(input int n, input logic eop_last, input logic fld, input logic [7:0] base);
        for (int i = 0; i < n; i++)
            drive(1'b1, 8'(i + int'(base)), eop_last && (i == n - 1), fld && (i == 10));
        if (!eop_last) drive(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic new_fill();
        exp_fill.delete();
        wcnt = 0;
    endtask

    task automatic fill_bank(input logic fld, input logic [7:0] base);
        new_fill();
        for (int p = 0; p < 8; p++) send_pkt(48, 1'b0, fld, base);
    endtask

    task automatic wait_drain(input int base, input int n, input int budget);
        int c;
        c = 0;
        while (cap.size() < base + n && c < budget) begin
            @(posedge clk); #1;
            c++;
        end
        check("drain_timeout", 32'(cap.size() >= base + n), 32'd1);
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic check_drain(input string tag, input int base, input int lc);
        int nerr;
        nerr = 0;
        check({tag, "_count"}, 32'(cap.size() - base), 32'(exp_drain.size()));
        for (int i = 0; i < exp_drain.size(); i++)
            if (base + i >= cap.size() || cap[base + i] !== exp_drain[i]) nerr++;
        check({tag, "_data_errs"}, 32'(nerr), 32'd0);
        check({tag, "_last_cnt"}, 32'(last_cnt - lc), 32'd1);
        check({tag, "_last_idx"}, 32'(last_idx), 32'(base + exp_drain.size() - 1));
    endtask

    initial begin
        int b, lc, rq, oc, n0, hc;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid",  32'(out_valid),  32'd0);
        check("rst_out_data",   32'(out_data),   32'd0);
        check("rst_out_last",   32'(out_last),   32'd0);
        check("rst_field_req",  32'(field_req),  32'd0);
        check("rst_bank_sel",   32'(bank_sel),   32'd0);
        check("rst_drain_busy", 32'(drain_busy), 32'd0);
        check("rst_overrun",    32'(overrun),    32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;

        // Plain bank with zeroed field window; out_valid two cycles after the swap.
        b = cap.size(); lc = last_cnt;
        fill_bank(1'b0, 8'h00);
        exp_drain = exp_fill;
        check("t1_bank_sel",   32'(bank_sel),   32'd1);
        check("t1_drain_busy", 32'(drain_busy), 32'd1);
        check("t1_valid_t0",   32'(out_valid),  32'd0);
        @(posedge clk); #1;
        check("t1_valid_t1",   32'(out_valid),  32'd0);
        @(posedge clk); #1;
        check("t1_valid_t2",   32'(out_valid),  32'd1);
        check("t1_first_byte", 32'(out_data),   32'h00);
        wait_drain(b, 384, 1200);
        check_drain("t1", b, lc);
        check("t1_byte34",  32'(cap[b + 34]),  32'h22);
        check("t1_byte35",  32'(cap[b + 35]),  32'h00);
        check("t1_byte47",  32'(cap[b + 47]),  32'h2F);
        check("t1_thruput", 32'(cap_t[b + 383] - cap_t[b]), 32'd766);
        check("t1_idle_busy",  32'(drain_busy), 32'd0);
        check("t1_idle_valid", 32'(out_valid),  32'd0);

        // Field splice each packet, drain held off by out_ready=0.
        out_ready = 1'b0;
        rq = req_cnt;
        b = cap.size(); lc = last_cnt;
        fill_bank(1'b1, 8'h00);
        exp_drain = exp_fill;
        check("t2_bank_sel", 32'(bank_sel), 32'd0);
        check("t2_req_cnt",  32'(req_cnt - rq), 32'd8);

        // Second fill while the drain is stalled: overrun, bank kept.
        repeat (4) @(posedge clk);
        #1;
        check("t3_held_valid", 32'(out_valid),  32'd1);
        check("t3_held_busy",  32'(drain_busy), 32'd1);
        oc = ovr_cnt;
        fill_bank(1'b0, 8'h80);
        check("t3_overrun",    32'(overrun),    32'd1);
        check("t3_bank_sel",   32'(bank_sel),   32'd0);
        check("t3_drain_busy", 32'(drain_busy), 32'd1);
        @(posedge clk); #1;
        check("t3_overrun_1cyc", 32'(overrun), 32'd0);
        check("t3_overrun_cnt",  32'(ovr_cnt - oc), 32'd1);
        check("t3_no_output",    32'(cap.size() - b), 32'd0);

        // Release, then a 10-cycle back-pressure window mid-drain.
        out_ready = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        hc = hold_cnt;
        out_ready = 1'b0;
        n0 = cap.size();
        repeat (10) @(posedge clk);
        #1;
        check("t4_stall_no_bytes", 32'(cap.size() - n0), 32'd0);
        out_ready = 1'b1;
        wait_drain(b, 384, 1200);
        check_drain("t4", b, lc);
        check("t4_byte34", 32'(cap[b + 34]), 32'h22);
        check("t4_byte35", 32'(cap[b + 35]), 32'h01);
        check("t4_byte45", 32'(cap[b + 45]), 32'h0B);
        check("t4_byte46", 32'(cap[b + 46]), 32'h2E);
        check("t4_hold_events", 32'(hold_cnt - hc >= 8), 32'd1);
        check("t4_hold_stable", 32'(hold_err), 32'd0);
        check("t4_gap_after_stall", 32'(cap_t[n0 + 2] - cap_t[n0 + 1]), 32'd2);

        // Same-cycle in_valid/in_eop, then 400 bytes into one bank.
        b = cap.size(); lc = last_cnt;
        new_fill();
        send_pkt(30, 1'b1, 1'b0, 8'h00);
        for (int p = 0; p < 6; p++) send_pkt(48, 1'b0, 1'b0, 8'h00);
        send_pkt(82, 1'b0, 1'b0, 8'h00);
        exp_drain = exp_fill;
        check("t5_bank_sel", 32'(bank_sel), 32'd1);
        wait_drain(b, 384, 1200);
        check_drain("t5", b, lc);
        check("t5_eop_byte_kept", 32'(cap[b + 29]), 32'h1D);
        check("t5_pkt1_byte0",    32'(cap[b + 30]), 32'h00);
        check("t5_pkt1_byte35",   32'(cap[b + 65]), 32'h01);
        check("t5_last_stored",   32'(cap[b + 383]), 32'h41);

        // Reset during a drain.
        fill_bank(1'b0, 8'h40);
        check("t6_bank_sel_pre", 32'(bank_sel), 32'd0);
        repeat (60) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid",    32'(out_valid),  32'd0);
        check("t6_rst_busy",     32'(drain_busy), 32'd0);
        check("t6_rst_bank_sel", 32'(bank_sel),   32'd0);
        tb_lat = '0;
        tb_idx = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n0 = cap.size();
        repeat (50) @(posedge clk);
        #1;
        check("t6_no_output",  32'(cap.size() - n0), 32'd0);
        check("t6_valid_idle", 32'(out_valid), 32'd0);
        b = cap.size(); lc = last_cnt;
        fill_bank(1'b0, 8'h10);
        exp_drain = exp_fill;
        check("t6_bank_sel_post", 32'(bank_sel), 32'd1);
        wait_drain(b, 384, 1200);
        check_drain("t6", b, lc);
        check("t6_byte0",  32'(cap[b]),      32'h10);
        check("t6_byte35", 32'(cap[b + 35]), 32'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
